game_state_tracker: RTL and testbench

Per-frame game-logic stage between the sprite/obstacle position updaters and the draw sequencer. Once per frame it takes a one-cycle `check` pulse, compares the player sprite and obstacle bounding boxes for overlap, and updates the score, lives and game-over status. The draw sequencer reads these outputs before it starts the sprite and obstacle draws.

---
 rtl/game_state_tracker.sv | 181 ++++++++++++++++++
 tb/tb_game_state_tracker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/game_state_tracker.sv
// Per-frame sprite/obstacle collision check updating BCD score, lives and sticky game-over; GAME_INVULN_EN adds post-hit immunity.
// Latency: done pulses 4 cycles after check is accepted; ready returns the cycle after done.
// Backpressure: check/restart are sampled only while ready=1; requests while busy are dropped, not queued.
`timescale 1ns/1ps
module game_state_tracker #(
  parameter int SPRITE_W      = 20,
  parameter int SPRITE_H      = 20,
  parameter int OBS_W         = 20,
  parameter int OBS_H         = 20,
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 10
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        check,
  input  logic        restart,
  input  logic [7:0]  xSprite,
  input  logic [8:0]  ySprite,
  input  logic [7:0]  xObstacle,
  input  logic [8:0]  yObstacle,
  output logic        ready,
  output logic        done,
  output logic        hit,
  output logic [15:0] score,
  output logic [2:0]  lives,
  output logic        gameOver
);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_OVERLAP, S_UPDATE, S_DONE
  } state_t;

  localparam logic [9:0] SPR_W10 = 10'(SPRITE_W);
  localparam logic [9:0] SPR_H10 = 10'(SPRITE_H);
  localparam logic [9:0] OBS_W10 = 10'(OBS_W);
  localparam logic [9:0] OBS_H10 = 10'(OBS_H);
  localparam logic [2:0] LIVES_INIT = 3'(LIVES);

  state_t     state, state_nxt;
  logic [7:0] x_s, x_o;
  logic [8:0] y_s, y_o, prev_y;
  logic       passed, hit_this, ovl, clr;
  logic       ovl_x, ovl_y, clr_nxt;

`ifdef GAME_INVULN_EN
  logic [7:0] inv_cnt;
`else
  logic unused_cfg;
  assign unused_cfg = (INVULN_FRAMES < 0);
`endif

  // The cycle that carries done still counts as busy, so a new accept lands after it.
  assign ready = (state == S_IDLE) && !done;

  assign ovl_x   = ({2'b00, x_s} < {2'b00, x_o} + OBS_W10) &&
                   ({2'b00, x_o} < {2'b00, x_s} + SPR_W10);
  assign ovl_y   = ({1'b0, y_s} < {1'b0, y_o} + OBS_H10) &&
                   ({1'b0, y_o} < {1'b0, y_s} + SPR_H10);
  assign clr_nxt = ({1'b0, y_o} + OBS_H10) <= {1'b0, y_s};

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (c) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (ready && check && !restart) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_OVERLAP;
      S_OVERLAP: state_nxt = S_UPDATE;
      S_UPDATE:  state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_s      <= '0;
      x_o      <= '0;
      y_s      <= '0;
      y_o      <= '0;
      prev_y   <= '0;
      passed   <= 1'b0;
      hit_this <= 1'b0;
      ovl      <= 1'b0;
      clr      <= 1'b0;
      done     <= 1'b0;
      hit      <= 1'b0;
      score    <= 16'h0000;
      lives    <= LIVES_INIT;
      gameOver <= 1'b0;
`ifdef GAME_INVULN_EN
      inv_cnt  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ready && restart) begin
            score    <= 16'h0000;
            lives    <= LIVES_INIT;
            gameOver <= 1'b0;
            passed   <= 1'b0;
            hit_this <= 1'b0;
`ifdef GAME_INVULN_EN
            inv_cnt  <= '0;
`endif
          end
        end
        S_CAPTURE: begin
          x_s    <= xSprite;
          y_s    <= ySprite;
          x_o    <= xObstacle;
          y_o    <= yObstacle;
          prev_y <= yObstacle;
          // Obstacles scroll toward smaller y, so a jump upward means a fresh one.
          if (yObstacle > prev_y) begin
            passed   <= 1'b0;
            hit_this <= 1'b0;
          end
        end
        S_OVERLAP: begin
          ovl <= ovl_x && ovl_y;
          clr <= clr_nxt;
        end
        S_UPDATE: begin
          if (!gameOver) begin
`ifdef GAME_INVULN_EN
            if (inv_cnt != '0) inv_cnt <= inv_cnt - 8'd1;
`endif
            if (ovl && !hit_this) begin
`ifdef GAME_INVULN_EN
              if (inv_cnt == '0) begin
                hit_this <= 1'b1;
                inv_cnt  <= 8'(INVULN_FRAMES);
                if (lives != 3'd0) lives <= lives - 3'd1;
                if (lives == 3'd1) gameOver <= 1'b1;
              end
`else
              hit_this <= 1'b1;
              if (lives != 3'd0) lives <= lives - 3'd1;
              if (lives == 3'd1) gameOver <= 1'b1;
`endif
            end else if (clr && !passed && !hit_this) begin
              passed <= 1'b1;
              score  <= bcd_inc(score);
            end
          end
        end
        S_DONE: begin
          done <= 1'b1;
          hit  <= ovl;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_tracker.sv
// Randomized and directed bench for game_state_tracker against a frame-level reference model.
`timescale 1ns/1ps
module tb_game_state_tracker;

  localparam int SPRITE_W = 20, SPRITE_H = 20, OBS_W = 20, OBS_H = 20, LIVES = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        check = 1'b0;
  logic        restart = 1'b0;
  logic [7:0]  xSprite = '0, xObstacle = '0;
  logic [8:0]  ySprite = '0, yObstacle = '0;
  logic        ready, done, hit, gameOver;
  logic [15:0] score;
  logic [2:0]  lives;

  game_state_tracker dut (
    .clock(clock), .reset_n(reset_n), .check(check), .restart(restart),
    .xSprite(xSprite), .ySprite(ySprite), .xObstacle(xObstacle), .yObstacle(yObstacle),
    .ready(ready), .done(done), .hit(hit), .score(score), .lives(lives), .gameOver(gameOver)
  );

  always #10 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: game rules in plain integer arithmetic.
  int m_prev, m_score, m_lives, pass_y;
  bit m_passed, m_ht, m_go, m_hit;

  function automatic void m_reset(input bit full);
    m_score = 0; m_lives = LIVES; m_go = 0; m_passed = 0; m_ht = 0;
    if (full) begin m_prev = 0; m_hit = 0; end
  endfunction

  function automatic void m_eval(input int xs, input int ys, input int xo, input int yo);
    bit ovl, clr;
    if (yo > m_prev) begin m_passed = 0; m_ht = 0; end
    m_prev = yo;
    ovl = (xs < xo + OBS_W) && (xo < xs + SPRITE_W) && (ys < yo + OBS_H) && (yo < ys + SPRITE_H);
    clr = (yo + OBS_H <= ys);
    if (!m_go) begin
      if (ovl && !m_ht) begin
        m_ht = 1;
        if (m_lives > 0) m_lives--;
        if (m_lives == 0) m_go = 1;
      end else if (clr && !m_passed && !m_ht) begin
        m_passed = 1;
        if (m_score < 9999) m_score++;
      end
    end
    m_hit = ovl;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, "_hit"}, 32'(hit), 32'(m_hit));
    chk({tag, "_score"}, 32'(score), 32'(to_bcd(m_score)));
    chk({tag, "_lives"}, 32'(lives), 32'(m_lives));
    chk({tag, "_gameover"}, 32'(gameOver), 32'(m_go));
  endtask

  // Entered and left at a negedge with ready=1.
  task automatic run_check(input int xs, input int ys, input int xo, input int yo, input bit verify);
    int lat;
    lat = 0;
    xSprite = 8'(xs); ySprite = 9'(ys); xObstacle = 8'(xo); yObstacle = 9'(yo);
    check = 1'b1;
    @(posedge clock); #1 check = 1'b0;
    @(negedge clock);
    if (verify) chk("busy_after_accept", 32'(ready), 0);
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      @(posedge clock); @(negedge clock);
      if (done) lat = i;
    end
    m_eval(xs, ys, xo, yo);
    chk("done_latency", lat, 4);
    if (verify) chk_state("chk");
    @(posedge clock); @(negedge clock);
    if (verify) begin
      chk("done_single", 32'(done), 0);
      chk("ready_back", 32'(ready), 1);
    end
  endtask

  task automatic do_restart(input bit with_check);
    restart = 1'b1; check = with_check;
    @(posedge clock); #1 restart = 1'b0; check = 1'b0;
    m_reset(0);
    @(negedge clock);
    chk("restart_score", 32'(score), 0);
    chk("restart_lives", 32'(lives), LIVES);
    chk("restart_gameover", 32'(gameOver), 0);
    @(posedge clock); @(negedge clock);
    chk("restart_idle", 32'(ready), 1);
  endtask

  task automatic do_pass(input bit verify);
    if (pass_y >= 491) begin
      run_check(0, 511, 200, 0, 0);
      pass_y = 0;
    end
    pass_y++;
    run_check(0, 511, 200, pass_y, verify);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nd;
    pass_y = 0;
    m_reset(1);
    repeat (3) @(negedge clock);
    chk("reset_ready", 32'(ready), 1);
    chk("reset_done", 32'(done), 0);
    chk_state("reset");
    reset_n = 1'b1;
    @(negedge clock);

    run_check(100, 119, 100, 130, 1);
    chk("first_hit_lives", 32'(lives), 2);
    run_check(100, 119, 100, 125, 1);
    run_check(100, 119, 100, 120, 1);
    run_check(100, 119, 200, 130, 1);
    run_check(100, 119, 200, 99, 1);
    chk("first_pass_score", 32'(score), 16'h0001);
    run_check(100, 119, 200, 90, 1);

    // check held high across a whole evaluation
    nd = 0;
    xSprite = 8'd100; ySprite = 9'd119; xObstacle = 8'd200; yObstacle = 9'd80;
    check = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); @(negedge clock);
      nd += int'(done);
    end
    check = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      nd += int'(done);
    end
    m_eval(100, 119, 200, 80);
    chk("held_check_one_eval", nd, 1);
    chk_state("held");

    // reset pulse while the evaluation is in OVERLAP
    run_check(100, 119, 100, 100, 1);
    xSprite = 8'd100; ySprite = 9'd119; xObstacle = 8'd100; yObstacle = 9'd110;
    check = 1'b1;
    @(posedge clock); #1 check = 1'b0;
    @(posedge clock); #5 reset_n = 1'b0;
    #3 reset_n = 1'b1;
    m_reset(1);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      nd += int'(done);
    end
    chk("reset_abort_no_done", nd, 0);
    chk("reset_abort_ready", 32'(ready), 1);
    chk_state("reset_abort");

    run_check(100, 140, 100, 130, 1);
    run_check(100, 140, 100, 140, 1);
    run_check(100, 140, 100, 150, 1);
    chk("three_hits_gameover", 32'(gameOver), 1);
    run_check(100, 140, 100, 155, 1);
    chk("held_after_gameover", 32'(lives), 0);
    do_restart(1'b1);

    while (m_score < 99) do_pass(1'b0);
    chk("score_0099", 32'(score), 16'h0099);
    do_pass(1'b1);
    chk("score_0100", 32'(score), 16'h0100);
    while (m_score < 9999) do_pass(1'b0);
    chk("score_9999", 32'(score), 16'h9999);
    do_pass(1'b1);
    chk("score_saturate", 32'(score), 16'h9999);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(11) == 0) begin
        do_restart(1'($urandom_range(1)));
      end else begin
        run_check(90 + int'($urandom_range(40)), 100 + int'($urandom_range(60)),
                  90 + int'($urandom_range(40)), int'($urandom_range(200)), 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
